// File: rtl/issue_perf_counters.sv
// Issue-stage perf counters: decodes per-cycle stall/dispatch events, registers
// them once, then accumulates into wrapping PERF_CTR_BITS-wide counters.
module issue_perf_counters #(
    parameter int PERF_CTR_BITS = 44,
    parameter int NUM_THREADS   = 4,
    parameter bit EXT_F_ENABLE  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     perf_freeze,
    input  logic                     decode_valid,
    input  logic                     ibuf_ready,
    input  logic                     ibuf_valid,
    input  logic                     scb_ready,
    input  logic                     disp_valid,
    input  logic [2:0]               disp_ex_type,
    input  logic [NUM_THREADS-1:0]   disp_tmask,
    input  logic [4:0]               unit_ready,
    output logic [PERF_CTR_BITS-1:0] ibf_stalls,
    output logic [PERF_CTR_BITS-1:0] scb_stalls,
    output logic [PERF_CTR_BITS-1:0] lsu_stalls,
    output logic [PERF_CTR_BITS-1:0] csr_stalls,
    output logic [PERF_CTR_BITS-1:0] alu_stalls,
    output logic [PERF_CTR_BITS-1:0] fpu_stalls,
    output logic [PERF_CTR_BITS-1:0] gpu_stalls,
    output logic [PERF_CTR_BITS-1:0] active_threads
);

    localparam int CNT_W  = $clog2(NUM_THREADS + 1);
    localparam int NUM_EV = 7;  // 0 ibf, 1 scb, 2+u unit stall (alu, lsu, csr, fpu, gpu)

    logic [NUM_EV-1:0]                    ev_d, ev_q;
    logic [CNT_W-1:0]                     thr_d, thr_q;
    logic [NUM_EV-1:0][PERF_CTR_BITS-1:0] stall_d, stall_q;
    logic [PERF_CTR_BITS-1:0]             thr_sum_d, thr_sum_q;
    logic                                 fire;

    always_comb begin
        ev_d    = '0;
        thr_d   = '0;
        fire    = 1'b0;
        ev_d[0] = decode_valid & ~ibuf_ready;
        ev_d[1] = ibuf_valid & ~scb_ready;
        // Reserved ex_type 5-7 match no unit, so they neither stall nor fire.
        for (int u = 0; u < 5; u++) begin
            if (disp_valid && disp_ex_type == 3'(u)) begin
                if (unit_ready[u]) fire = 1'b1;
                else               ev_d[2+u] = 1'b1;
            end
        end
        if (!EXT_F_ENABLE) ev_d[5] = 1'b0;
        if (fire) begin
            for (int t = 0; t < NUM_THREADS; t++)
                thr_d = thr_d + CNT_W'(disp_tmask[t]);
        end
    end

    always_comb begin
        stall_d   = stall_q;
        thr_sum_d = thr_sum_q;
        // A frozen cycle drops whatever stage 1 holds rather than deferring it.
        if (!perf_freeze) begin
            for (int e = 0; e < NUM_EV; e++)
                stall_d[e] = stall_q[e] + PERF_CTR_BITS'(ev_q[e]);
            thr_sum_d = thr_sum_q + PERF_CTR_BITS'(thr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ev_q      <= '0;
            thr_q     <= '0;
            stall_q   <= '0;
            thr_sum_q <= '0;
        end else begin
            ev_q      <= ev_d;
            thr_q     <= thr_d;
            stall_q   <= stall_d;
            thr_sum_q <= thr_sum_d;
        end
    end

    assign ibf_stalls     = stall_q[0];
    assign scb_stalls     = stall_q[1];
    assign alu_stalls     = stall_q[2];
    assign lsu_stalls     = stall_q[3];
    assign csr_stalls     = stall_q[4];
    // Without EXT_F the fpu event is masked, so this counter never leaves 0.
    assign fpu_stalls     = stall_q[5];
    assign gpu_stalls     = stall_q[6];
    assign active_threads = thr_sum_q;

endmodule

// File: tb/tb_issue_perf_counters.sv
// Bench for issue_perf_counters: a 44-bit/FPU build and an 8-bit/no-FPU build
// share stimulus; directed table, hand sequences and random traffic vs a model.
module tb_issue_perf_counters;

    localparam int MAXC = 2048;
    typedef logic [7:0][63:0] cnt8_t;  // [0]ibf [1]scb [2]alu [3]lsu [4]csr [5]fpu [6]gpu [7]thr

    typedef struct {
        logic       dv, ir, iv, sr, dval;
        logic [2:0] ex;
        logic [3:0] tm;
        logic [4:0] ur;
        int         n;
        cnt8_t      exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, perf_freeze, decode_valid, ibuf_ready, ibuf_valid, scb_ready, disp_valid;
    logic [2:0] disp_ex_type;
    logic [3:0] disp_tmask;
    logic [4:0] unit_ready;
    logic [43:0] a_ibf, a_scb, a_lsu, a_csr, a_alu, a_fpu, a_gpu, a_thr;
    logic [7:0]  b_ibf, b_scb, b_lsu, b_csr, b_alu, b_fpu, b_gpu, b_thr;

    issue_perf_counters u_dut (
        .clk(clk), .reset(reset), .perf_freeze(perf_freeze),
        .decode_valid(decode_valid), .ibuf_ready(ibuf_ready),
        .ibuf_valid(ibuf_valid), .scb_ready(scb_ready),
        .disp_valid(disp_valid), .disp_ex_type(disp_ex_type),
        .disp_tmask(disp_tmask), .unit_ready(unit_ready),
        .ibf_stalls(a_ibf), .scb_stalls(a_scb), .lsu_stalls(a_lsu), .csr_stalls(a_csr),
        .alu_stalls(a_alu), .fpu_stalls(a_fpu), .gpu_stalls(a_gpu), .active_threads(a_thr)
    );

    issue_perf_counters #(.PERF_CTR_BITS(8), .NUM_THREADS(4), .EXT_F_ENABLE(1'b0)) u_dut8 (
        .clk(clk), .reset(reset), .perf_freeze(perf_freeze),
        .decode_valid(decode_valid), .ibuf_ready(ibuf_ready),
        .ibuf_valid(ibuf_valid), .scb_ready(scb_ready),
        .disp_valid(disp_valid), .disp_ex_type(disp_ex_type),
        .disp_tmask(disp_tmask), .unit_ready(unit_ready),
        .ibf_stalls(b_ibf), .scb_stalls(b_scb), .lsu_stalls(b_lsu), .csr_stalls(b_csr),
        .alu_stalls(b_alu), .fpu_stalls(b_fpu), .gpu_stalls(b_gpu), .active_threads(b_thr)
    );

    int  n_chk = 0, n_fail = 0, cyc = 0;
    bit  h_rst[MAXC];
    bit  h_frz[MAXC];
    int  h_ev[MAXC][8];
    vec_t tbl[10];

    function automatic cnt8_t got_a();
        cnt8_t g;
        g[0] = 64'(a_ibf); g[1] = 64'(a_scb); g[2] = 64'(a_alu); g[3] = 64'(a_lsu);
        g[4] = 64'(a_csr); g[5] = 64'(a_fpu); g[6] = 64'(a_gpu); g[7] = 64'(a_thr);
        return g;
    endfunction

    function automatic cnt8_t got_b();
        cnt8_t g;
        g[0] = 64'(b_ibf); g[1] = 64'(b_scb); g[2] = 64'(b_alu); g[3] = 64'(b_lsu);
        g[4] = 64'(b_csr); g[5] = 64'(b_fpu); g[6] = 64'(b_gpu); g[7] = 64'(b_thr);
        return g;
    endfunction

    function automatic cnt8_t mk_exp(int ibf, int scb, int alu, int lsu, int csr, int fpu, int gpu, int thr);
        cnt8_t e;
        e[0] = 64'(ibf); e[1] = 64'(scb); e[2] = 64'(alu); e[3] = 64'(lsu);
        e[4] = 64'(csr); e[5] = 64'(fpu); e[6] = 64'(gpu); e[7] = 64'(thr);
        return e;
    endfunction

    // View of a wide expectation through the 8-bit, FPU-less build.
    function automatic cnt8_t narrow(cnt8_t x);
        cnt8_t e = x;
        e[5] = '0;
        for (int i = 0; i < 8; i++) e[i] = e[i] % 256;
        return e;
    endfunction

    // Counters seen in cycle c = sum of events from cycles k after the last reset
    // seen before c, with k <= c-2, excluding those whose next cycle was frozen.
    function automatic cnt8_t model_at(int c, bit nar);
        int    r = -1;
        cnt8_t s = '0;
        for (int k = 0; k < c; k++) if (h_rst[k]) r = k;
        for (int k = r + 1; k <= c - 2; k++)
            if (!h_frz[k+1])
                for (int e = 0; e < 8; e++) s[e] = s[e] + 64'(h_ev[k][e]);
        return nar ? narrow(s) : s;
    endfunction

    function automatic vec_t mkv(logic dv, ir, iv, sr, dval, logic [2:0] ex, logic [3:0] tm,
                                 logic [4:0] ur, int n, cnt8_t exp);
        vec_t v;
        v.dv = dv; v.ir = ir; v.iv = iv; v.sr = sr; v.dval = dval;
        v.ex = ex; v.tm = tm; v.ur = ur; v.n = n; v.exp = exp;
        return v;
    endfunction

    task automatic chk(string nm, cnt8_t got, cnt8_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic idle_in();
        reset = 1'b1; perf_freeze = 1'b0;
        decode_valid = 1'b0; ibuf_ready = 1'b1; ibuf_valid = 1'b0; scb_ready = 1'b1;
        disp_valid = 1'b0; disp_ex_type = 3'd0; disp_tmask = 4'h0; unit_ready = 5'h1f;
    endtask

    // Record this cycle's inputs for the model, check mid-cycle, advance one clock.
    task automatic tick();
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        h_rst[cyc] = !reset;
        h_frz[cyc] = perf_freeze;
        for (int e = 0; e < 8; e++) h_ev[cyc][e] = 0;
        h_ev[cyc][0] = (decode_valid && !ibuf_ready) ? 1 : 0;
        h_ev[cyc][1] = (ibuf_valid && !scb_ready) ? 1 : 0;
        if (disp_valid && disp_ex_type <= 3'd4) begin
            if (unit_ready[disp_ex_type]) h_ev[cyc][7] = $countones(disp_tmask);
            else                          h_ev[cyc][2 + int'(disp_ex_type)] = 1;
        end
        @(negedge clk);
        chk("model_w44", got_a(), model_at(cyc, 1'b0));
        chk("model_w8", got_b(), model_at(cyc, 1'b1));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic run_stall_ibf(int n);
        decode_valid = 1'b1; ibuf_ready = 1'b0;
        repeat (n) tick();
        decode_valid = 1'b0; ibuf_ready = 1'b1;
    endtask

    initial begin
        cnt8_t ex;
        tbl[0] = mkv(1, 0, 0, 1, 0, 3'd0, 4'h0, 5'h1f, 5, mk_exp(5, 0, 0, 0, 0, 0, 0, 0));
        tbl[1] = mkv(0, 1, 1, 0, 0, 3'd0, 4'h0, 5'h1f, 4, mk_exp(0, 4, 0, 0, 0, 0, 0, 0));
        tbl[2] = mkv(0, 1, 0, 1, 1, 3'd1, 4'h0, 5'b11101, 3, mk_exp(0, 0, 0, 3, 0, 0, 0, 0));
        tbl[3] = mkv(0, 1, 0, 1, 1, 3'd1, 4'b1011, 5'h1f, 1, mk_exp(0, 0, 0, 0, 0, 0, 0, 3));
        tbl[4] = mkv(0, 1, 0, 1, 1, 3'd0, 4'hf, 5'b11110, 2, mk_exp(0, 0, 2, 0, 0, 0, 0, 0));
        tbl[5] = mkv(0, 1, 0, 1, 1, 3'd2, 4'hf, 5'b11011, 3, mk_exp(0, 0, 0, 0, 3, 0, 0, 0));
        tbl[6] = mkv(0, 1, 0, 1, 1, 3'd3, 4'hf, 5'b10111, 4, mk_exp(0, 0, 0, 0, 0, 4, 0, 0));
        tbl[7] = mkv(0, 1, 0, 1, 1, 3'd6, 4'hf, 5'b00000, 4, mk_exp(0, 0, 0, 0, 0, 0, 0, 0));
        tbl[8] = mkv(1, 0, 1, 0, 1, 3'd4, 4'hf, 5'b01111, 6, mk_exp(6, 6, 0, 0, 0, 0, 6, 0));
        tbl[9] = mkv(0, 1, 0, 1, 1, 3'd3, 4'hf, 5'h1f, 2, mk_exp(0, 0, 0, 0, 0, 0, 0, 8));

        idle_in();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        reset = 1'b1;

        repeat (10) tick();
        chk("reset_idle_w44", got_a(), '0);
        chk("reset_idle_w8", got_b(), '0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            decode_valid = tbl[i].dv; ibuf_ready = tbl[i].ir; ibuf_valid = tbl[i].iv;
            scb_ready = tbl[i].sr; disp_valid = tbl[i].dval; disp_ex_type = tbl[i].ex;
            disp_tmask = tbl[i].tm; unit_ready = tbl[i].ur;
            repeat (tbl[i].n) tick();
            idle_in();
            repeat (2) tick();
            chk($sformatf("table%0d_w44", i), got_a(), tbl[i].exp);
            chk($sformatf("table%0d_w8", i), got_b(), narrow(tbl[i].exp));
        end

        // Two-cycle latency and hold after the burst ends.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            decode_valid = (i < 5); ibuf_ready = !(i < 5);
            tick();
            chk($sformatf("ibf_latency_c%0d", i + 1), got_a(),
                mk_exp((i > 5) ? 5 : i, 0, 0, 0, 0, 0, 0, 0));
        end

        // LSU stalls then a fire on the same unit.
        do_reset();
        disp_valid = 1'b1; disp_ex_type = 3'd1; unit_ready = 5'b11101; disp_tmask = 4'b1011;
        repeat (3) tick();
        unit_ready = 5'h1f;
        tick();
        idle_in();
        repeat (2) tick();
        chk("lsu_then_fire", got_a(), mk_exp(0, 0, 0, 3, 0, 0, 0, 3));

        // Mid-run reset at 7, with events in flight around the reset cycle.
        do_reset();
        run_stall_ibf(7);
        repeat (2) tick();
        chk("pre_reset_7", got_a(), mk_exp(7, 0, 0, 0, 0, 0, 0, 0));
        decode_valid = 1'b1; ibuf_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post_reset_%0d", i), got_a(), '0);
            tick();
        end

        // Freeze over cycles 10-14 of a 20-cycle stall burst.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            decode_valid = 1'b1; ibuf_ready = 1'b0;
            perf_freeze = (i >= 10 && i <= 14);
            tick();
            if (i >= 10 && i <= 14)
                chk($sformatf("frozen_c%0d", i + 1), got_a(), mk_exp(9, 0, 0, 0, 0, 0, 0, 0));
        end
        idle_in();
        repeat (2) tick();
        chk("freeze_final", got_a(), mk_exp(15, 0, 0, 0, 0, 0, 0, 0));

        // Wrap in the 8-bit build.
        do_reset();
        run_stall_ibf(254);
        repeat (2) tick();
        chk("wrap_254_w8", got_b(), narrow(mk_exp(254, 0, 0, 0, 0, 0, 0, 0)));
        run_stall_ibf(3);
        repeat (2) tick();
        chk("wrap_257_w8", got_b(), narrow(mk_exp(257, 0, 0, 0, 0, 0, 0, 0)));
        chk("wrap_257_w44", got_a(), mk_exp(257, 0, 0, 0, 0, 0, 0, 0));
        disp_valid = 1'b1; disp_ex_type = 3'd0; disp_tmask = 4'hf;
        repeat (64) tick();
        idle_in();
        repeat (2) tick();
        ex = mk_exp(257, 0, 0, 0, 0, 0, 0, 256);
        chk("thr_wrap_w8", got_b(), narrow(ex));
        chk("thr_wrap_w44", got_a(), ex);

        // Random traffic, checked every cycle against the model inside tick().
        for (int i = 0; i < 500; i++) begin
            reset        = ($urandom_range(0, 49) != 0);
            perf_freeze  = ($urandom_range(0, 9) == 0);
            decode_valid = 1'($urandom());
            ibuf_ready   = 1'($urandom());
            ibuf_valid   = 1'($urandom());
            scb_ready    = 1'($urandom());
            disp_valid   = 1'($urandom());
            disp_ex_type = 3'($urandom_range(0, 7));
            disp_tmask   = 4'($urandom());
            unit_ready   = 5'($urandom());
            tick();
        end
        idle_in();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
